// File: rtl/bcd_operand_entry.sv
// Keypad front end for the BCD calculator: builds two sign-magnitude BCD
// operands and an opcode from key strokes, captures the ALU result on '='
// and chooses the value to show on the display.
module bcd_operand_entry #(
    parameter logic [2:0] OP_ADD     = 3'b001,
    parameter logic [2:0] OP_SUB     = 3'b010,
    parameter int         MAX_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [8:0] alu_result,
    output logic [8:0] op1,
    output logic [8:0] op2,
    output logic [2:0] opcode,
    output logic [8:0] disp_val,
    output logic       result_valid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ENTER_OP1   = 2'b00,
        ENTER_OP2   = 2'b01,
        SHOW_RESULT = 2'b10
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_NEG = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;

    localparam logic [1:0] DIGIT_LIMIT = 2'(MAX_DIGITS);

    state_t     state_q, state_n;
    logic [8:0] op1_n, op2_n, res_q, res_n, disp_n;
    logic [2:0] opcode_n;
    logic [1:0] digit_cnt, cnt_n;
    logic       rv_n;
    logic       is_digit, is_arith;

    // Shift a new BCD digit into the ones place; the old tens digit drops out.
    function automatic logic [8:0] shift_digit(input logic [8:0] x, input logic [3:0] d);
        return {x[8], x[3:0], d};
    endfunction

    // Flip the sign of a non-zero magnitude; zero stays positive so -0 never appears.
    function automatic logic [8:0] negate(input logic [8:0] x);
        return (x[7:0] != 8'h00) ? {~x[8], x[7:0]} : x;
    endfunction

    assign is_digit = (key_code <= 4'd9);
    assign is_arith = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    assign state    = state_q;

    // State and operand registers; reset returns every output to its idle value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ENTER_OP1;
            op1          <= '0;
            op2          <= '0;
            opcode       <= OP_ADD;
            res_q        <= '0;
            digit_cnt    <= '0;
            result_valid <= 1'b0;
            disp_val     <= '0;
        end else begin
            state_q      <= state_n;
            op1          <= op1_n;
            op2          <= op2_n;
            opcode       <= opcode_n;
            res_q        <= res_n;
            digit_cnt    <= cnt_n;
            result_valid <= rv_n;
            disp_val     <= disp_n;
        end
    end

    // Key decode: next state, operand updates and the display selection.
    always_comb begin
        state_n  = state_q;
        op1_n    = op1;
        op2_n    = op2;
        opcode_n = opcode;
        res_n    = res_q;
        cnt_n    = digit_cnt;
        rv_n     = 1'b0;
        disp_n   = '0;

        if (key_valid) begin
            if (key_code == KEY_CLR) begin
                state_n  = ENTER_OP1;
                op1_n    = '0;
                op2_n    = '0;
                opcode_n = OP_ADD;
                res_n    = '0;
                cnt_n    = '0;
            end else begin
                case (state_q)
                    ENTER_OP1: begin
                        if (is_digit) begin
                            if (digit_cnt < DIGIT_LIMIT) begin
                                op1_n = shift_digit(op1, key_code);
                                cnt_n = digit_cnt + 2'd1;
                            end
                        end else if (key_code == KEY_NEG) begin
                            op1_n = negate(op1);
                        end else if (is_arith) begin
                            opcode_n = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
                            op2_n    = '0;
                            cnt_n    = '0;
                            state_n  = ENTER_OP2;
                        end
                    end
                    ENTER_OP2: begin
                        if (is_digit) begin
                            if (digit_cnt < DIGIT_LIMIT) begin
                                op2_n = shift_digit(op2, key_code);
                                cnt_n = digit_cnt + 2'd1;
                            end
                        end else if (key_code == KEY_NEG) begin
                            op2_n = negate(op2);
                        end else if (is_arith) begin
                            opcode_n = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
                        end else if (key_code == KEY_EQ) begin
                            // Operands stay put so the ALU output is stable at the capture edge.
                            res_n   = alu_result;
                            rv_n    = 1'b1;
                            state_n = SHOW_RESULT;
                        end
                    end
                    SHOW_RESULT: begin
                        if (is_digit) begin
                            op1_n   = {1'b0, 4'h0, key_code};
                            op2_n   = '0;
                            cnt_n   = 2'd1;
                            state_n = ENTER_OP1;
                        end else if (is_arith) begin
                            op1_n    = res_q;
                            op2_n    = '0;
                            opcode_n = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
                            cnt_n    = '0;
                            state_n  = ENTER_OP2;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Display follows the values that will be registered on this edge.
        case (state_n)
            ENTER_OP1:   disp_n = op1_n;
            ENTER_OP2:   disp_n = (cnt_n == 2'd0) ? op1_n : op2_n;
            SHOW_RESULT: disp_n = res_n;
            default:     disp_n = op1_n;
        endcase
    end

endmodule
